x_argmax_classifier: RTL and testbench
======================================

// Module: x_argmax_classifier
// PURPOSE
//  Consumes the result matrix X [N x M] written by the matrix multiplier and labels each pixel.
//  Rows are classes (LCMV filter outputs); columns are pixels.
//  Reads X one column at a time through the column read port and finds the row holding the
//  largest FP32 score. Emits (pixel, class, score) on a valid/ready stream.
//  Sits directly downstream of matrix_multiplier and is started after its finished pulse.
// PARAMETERS
//  N      4   classes = rows of X
//  M      3   pixels = columns of X
//  WIDTH  32  scalar width; IEEE-754 single only
// PORTS
//  clk               in   1                 clock, rising edge
//  rst               in   1                 asynchronous, active-low reset
//  start             in   1                 begin classification; sampled only in IDLE
//  finished          out  1                 one-cycle pulse after the last pixel is emitted
//  x_col_addr        out  $clog2(M)         column to read
//  x_col_addr_ready  out  1                 one-cycle read request
//  x_col_valid       in   1                 x_col_out valid (memory latency >= 1, variable)
//  x_col_out         in   N*WIDTH           column data; row r at bits [r*WIDTH +: WIDTH]
//  class_valid       out  1                 result beat valid
//  class_ready       in   1                 downstream accepts beat
//  class_pixel       out  $clog2(M)         pixel (column) index of the beat
//  class_idx         out  $clog2(N)         winning row
//  class_score       out  WIDTH             winning score, raw bits
// BEHAVIOUR
//  Reset: state IDLE, all counters 0. Every output is 0 while rst=0 and after release.
//  FSM states and transitions:
//   IDLE  start=1 -> REQ; column counter c <= 0.
//   REQ   x_col_addr=c, x_col_addr_ready=1 for exactly one cycle -> WAIT.
//   WAIT  on x_col_valid: latch column; best <= row 0; r <= 1 -> SCAN (or -> EMIT when N=1).
//   SCAN  one row per cycle: replace best when key(row r) > key(best), strictly greater.
//         r==N-1 -> EMIT.
//   EMIT  class_valid=1; class_* held stable until class_ready.
//         On handshake: if c==M-1 -> DONE, else c++ -> REQ.
//   DONE  finished=1 for one cycle -> IDLE.
//  Ordering key: key(x) = x[31] ? ~x : (x | 32'h8000_0000); compare keys unsigned.
//   - +0 beats -0.
//   - Ties: the lowest row index wins.
//   - NaN inputs are out of contract.
//  Per-pixel latency from REQ: 1 + memory latency + (N-1) + 1 cycles, plus any backpressure.
//  Boundaries:
//   - x_col_valid outside WAIT is ignored.
//   - start outside IDLE is ignored.
//   - class_ready high before class_valid has no effect.
//   - Column counter never wraps mid-run: M-1 is the last column.
//   - Reset asserted mid-run aborts immediately: no finished pulse, and a pending beat is dropped.
// STRUCTURE
//  Shared package lcmv_pkg: fp32_key() function, state_t enum, FP32 constants
//  (POS_ZERO, NEG_ZERO, ONE, MINUS_ONE).
//  One sub-module: fp32_greater (combinational, a > b by key). It is reused by later
//  normalisation stages.
//  Column counter uses counter_mod (MOD=M); row scan counter uses counter_mod (MOD=N).
//  Counter reset ports are driven from the FSM.
// TESTING
//  1. N=4, M=3. Columns {1.0,2.0,-1.0,0.5}, {-2.0,-1.0,-3.0,-4.0}, {0,0,0,0}.
//     -> beats (0,1,0x40000000), (1,1,0xBF800000), (2,0,0x00000000).
//     finished fires once, one cycle after the third handshake.
//  2. Backpressure: class_ready=0 for 5 cycles in EMIT.
//     -> class_* stable throughout; no new x_col_addr_ready until the handshake.
//  3. Signed zero and ties.
//     Column {0x80000000, 0x00000000, 0x00000000, 0x80000000} -> class_idx=1.
//     Column {2.0, 2.0, 1.0, 1.0} -> class_idx=0.
//  4. Memory latency 1 vs 7 cycles with a spurious x_col_valid during SCAN.
//     -> identical beats; the spurious pulse is ignored.
//  5. Reset (rst=0) asserted during SCAN of pixel 1.
//     -> outputs 0 asynchronously; after release, start reruns from pixel 0 correctly.
//  6. N=1, M=1: column {-5.0} -> single beat (0,0,0xC0A00000), then finished.

Source files
------------

// File: rtl/lcmv_pkg.sv
// Shared definitions for the LCMV classification back end: FSM encoding,
// FP32 constants and the total-order key used to compare FP32 scores.
package lcmv_pkg;

    localparam int FP32_W = 32;

    localparam logic [31:0] POS_ZERO  = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO  = 32'h8000_0000;
    localparam logic [31:0] ONE       = 32'h3F80_0000;
    localparam logic [31:0] MINUS_ONE = 32'hBF80_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SCAN = 3'd3,
        ST_EMIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Maps FP32 bits onto an unsigned key whose order matches numeric order, with +0 above -0.
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        if (x[31]) begin
            return ~x;
        end else begin
            return x | 32'h8000_0000;
        end
    endfunction

endpackage

// File: rtl/counter_mod.sv
// Modulo-MOD up counter with asynchronous reset, synchronous clear and
// count enable; last flags the terminal value MOD-1.
module counter_mod #(
    parameter  int MOD = 4,
    localparam int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(MOD - 1));

    // Count register: clear has priority over enable, wraps after MOD-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/fp32_greater.sv
// Combinational FP32 comparison: gt is high when a orders strictly above b.
module fp32_greater
    import lcmv_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    assign gt = (fp32_key(a) > fp32_key(b));

endmodule

// File: rtl/x_argmax_classifier.sv
// Labels each pixel (column of X) with the row holding the largest FP32 score
// and streams (pixel, class, score) beats out on a valid/ready interface.
module x_argmax_classifier
    import lcmv_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int M     = 3,
    parameter  int WIDTH = 32,
    localparam int AW    = (M > 1) ? $clog2(M) : 1,
    localparam int RW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             finished,
    output logic [AW-1:0]    x_col_addr,
    output logic             x_col_addr_ready,
    input  logic             x_col_valid,
    input  logic [N*WIDTH-1:0] x_col_out,
    output logic             class_valid,
    input  logic             class_ready,
    output logic [AW-1:0]    class_pixel,
    output logic [RW-1:0]    class_idx,
    output logic [WIDTH-1:0] class_score
);

    state_t             state_r;
    state_t             state_nxt_s;
    logic               col_clr_s;
    logic               col_en_s;
    logic [AW-1:0]      col_cnt_s;
    logic               col_last_s;
    logic               row_clr_s;
    logic               row_en_s;
    logic [RW-1:0]      row_cnt_s;
    logic               row_last_s;
    logic [WIDTH-1:0]   col_r [N];
    logic [WIDTH-1:0]   row_data_s;
    logic [WIDTH-1:0]   best_score_r;
    logic [RW-1:0]      best_idx_r;
    logic               row_gt_s;
    logic               handshake_s;
    logic               addr_ready_r;
    logic               class_valid_r;
    logic               finished_r;
    logic [AW-1:0]      class_pixel_r;

    counter_mod #(.MOD(M)) u_col_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (col_clr_s),
        .en   (col_en_s),
        .cnt  (col_cnt_s),
        .last (col_last_s)
    );

    counter_mod #(.MOD(N)) u_row_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (row_clr_s),
        .en   (row_en_s),
        .cnt  (row_cnt_s),
        .last (row_last_s)
    );

    fp32_greater u_cmp (
        .a  (row_data_s),
        .b  (best_score_r),
        .gt (row_gt_s)
    );

    assign handshake_s = class_valid_r & class_ready;

    // Row select for the scan compare.
    always_comb begin
        row_data_s = '0;
        for (int i = 0; i < N; i++) begin
            if (row_cnt_s == RW'(i)) begin
                row_data_s = col_r[i];
            end else begin
                row_data_s = row_data_s;
            end
        end
    end

    // Next-state logic; also drives the counter clear/enable controls.
    always_comb begin
        state_nxt_s = state_r;
        col_clr_s   = 1'b0;
        col_en_s    = 1'b0;
        row_clr_s   = 1'b0;
        row_en_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_REQ;
                    col_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                state_nxt_s = ST_WAIT;
                row_clr_s   = 1'b1;
            end
            ST_WAIT: begin
                // Row 0 is the initial best, so the scan starts at row 1; N=1 skips it.
                if (x_col_valid) begin
                    row_en_s    = 1'b1;
                    state_nxt_s = row_last_s ? ST_EMIT : ST_SCAN;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SCAN: begin
                row_en_s = 1'b1;
                if (row_last_s) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_EMIT: begin
                if (handshake_s) begin
                    if (col_last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_REQ;
                        col_en_s    = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Column capture and running best; strict compare keeps the lowest row on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                col_r[i] <= '0;
            end
            best_score_r <= '0;
            best_idx_r   <= '0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (x_col_valid) begin
                        for (int i = 0; i < N; i++) begin
                            col_r[i] <= x_col_out[i*WIDTH +: WIDTH];
                        end
                        best_score_r <= x_col_out[WIDTH-1:0];
                        best_idx_r   <= '0;
                    end else begin
                        best_score_r <= best_score_r;
                        best_idx_r   <= best_idx_r;
                    end
                end
                ST_SCAN: begin
                    if (row_gt_s) begin
                        best_score_r <= row_data_s;
                        best_idx_r   <= row_cnt_s;
                    end else begin
                        best_score_r <= best_score_r;
                        best_idx_r   <= best_idx_r;
                    end
                end
                default: begin
                    best_score_r <= best_score_r;
                    best_idx_r   <= best_idx_r;
                end
            endcase
        end
    end

    // Output strobes registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_ready_r  <= 1'b0;
            class_valid_r <= 1'b0;
            finished_r    <= 1'b0;
            class_pixel_r <= '0;
        end else begin
            addr_ready_r  <= (state_nxt_s == ST_REQ);
            class_valid_r <= (state_nxt_s == ST_EMIT);
            finished_r    <= (state_nxt_s == ST_DONE);
            if (state_nxt_s == ST_EMIT) begin
                class_pixel_r <= col_cnt_s;
            end else begin
                class_pixel_r <= class_pixel_r;
            end
        end
    end

    assign x_col_addr       = col_cnt_s;
    assign x_col_addr_ready = addr_ready_r;
    assign class_valid      = class_valid_r;
    assign class_pixel      = class_pixel_r;
    assign class_idx        = best_idx_r;
    assign class_score      = best_score_r;
    assign finished         = finished_r;

endmodule

// File: tb/tb_x_argmax_classifier.sv
// Bench for x_argmax_classifier: table vectors, random columns against a
// numeric-order reference, backpressure, latency, abort and N=1/M=1 cases.
module tb_x_argmax_classifier;

    localparam int N = 4;
    localparam int M = 3;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             finished;
    logic [1:0]       x_col_addr;
    logic             x_col_addr_ready;
    logic             x_col_valid;
    logic [N*W-1:0]   x_col_out;
    logic             class_valid;
    logic             class_ready;
    logic [1:0]       class_pixel;
    logic [1:0]       class_idx;
    logic [31:0]      class_score;

    logic             start1;
    logic             finished1;
    logic [0:0]       x_col_addr1;
    logic             x_col_addr_ready1;
    logic             x_col_valid1;
    logic [31:0]      x_col_out1;
    logic             class_valid1;
    logic             class_ready1;
    logic [0:0]       class_pixel1;
    logic [0:0]       class_idx1;
    logic [31:0]      class_score1;

    always #5 clk = ~clk;

    x_argmax_classifier #(.N(4), .M(3), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .finished(finished),
        .x_col_addr(x_col_addr), .x_col_addr_ready(x_col_addr_ready),
        .x_col_valid(x_col_valid), .x_col_out(x_col_out),
        .class_valid(class_valid), .class_ready(class_ready),
        .class_pixel(class_pixel), .class_idx(class_idx), .class_score(class_score)
    );

    x_argmax_classifier #(.N(1), .M(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .finished(finished1),
        .x_col_addr(x_col_addr1), .x_col_addr_ready(x_col_addr_ready1),
        .x_col_valid(x_col_valid1), .x_col_out(x_col_out1),
        .class_valid(class_valid1), .class_ready(class_ready1),
        .class_pixel(class_pixel1), .class_idx(class_idx1), .class_score(class_score1)
    );

    typedef struct {
        logic [N*W-1:0] col;
        int             idx;
        logic [31:0]    score;
    } vec_t;

    vec_t           vecs [6];
    logic [N*W-1:0] mem [M];
    int             exp_idx [M];
    logic [31:0]    exp_sc [M];
    int             mem_lat = 1;
    bit             mem_spur = 1'b0;
    int             fin_count = 0;
    int             checks = 0;
    int             failures = 0;
    string          cur_tag = "init";

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s actual=%h required=%h", cur_tag, name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] mk(input logic [31:0] r0, input logic [31:0] r1,
                                          input logic [31:0] r2, input logic [31:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    // Numeric "a > b" using sign-magnitude reasoning; +0 counts above -0.
    function automatic bit num_greater(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return b[31];
        if (!a[31]) return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    task automatic ref_argmax(input logic [N*W-1:0] col, output int idx, output logic [31:0] sc);
        idx = 0;
        sc  = col[31:0];
        for (int r = 1; r < N; r++) begin
            if (num_greater(col[r*W +: W], sc)) begin
                idx = r;
                sc  = col[r*W +: W];
            end
        end
    endtask

    function automatic logic [31:0] rnd_f();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'h3F80_0000;
            3: v = 32'hBF80_0000;
            default: begin
                v = $urandom;
                if (v[30:23] == 8'hFF) v[30] = 1'b0;
            end
        endcase
        return v;
    endfunction

    // Column memory: answers each read request after mem_lat cycles, optional stray pulse.
    initial begin
        logic [1:0] a;
        x_col_valid = 1'b0;
        x_col_out   = '0;
        forever begin
            @(negedge clk);
            if (x_col_addr_ready === 1'b1) begin
                a = x_col_addr;
                repeat (mem_lat) @(negedge clk);
                x_col_valid = 1'b1;
                x_col_out   = mem[a];
                @(negedge clk);
                x_col_valid = 1'b0;
                x_col_out   = '0;
                if (mem_spur) begin
                    @(negedge clk);
                    x_col_valid = 1'b1;
                    x_col_out   = {N{32'h7F00_0000}};
                    @(negedge clk);
                    x_col_valid = 1'b0;
                    x_col_out   = '0;
                end
            end
        end
    end

    // Single-row memory for the N=1 instance.
    initial begin
        x_col_valid1 = 1'b0;
        x_col_out1   = '0;
        forever begin
            @(negedge clk);
            if (x_col_addr_ready1 === 1'b1) begin
                repeat (2) @(negedge clk);
                x_col_valid1 = 1'b1;
                x_col_out1   = 32'hC0A0_0000;
                @(negedge clk);
                x_col_valid1 = 1'b0;
                x_col_out1   = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (finished === 1'b1) fin_count <= fin_count + 1;
    end

    task automatic check_idle(input string tag);
        cur_tag = tag;
        chk("addr_ready", 32'(x_col_addr_ready), 32'd0);
        chk("class_valid", 32'(class_valid), 32'd0);
        chk("finished", 32'(finished), 32'd0);
        chk("class_pixel", 32'(class_pixel), 32'd0);
        chk("class_idx", 32'(class_idx), 32'd0);
        chk("class_score", class_score, 32'd0);
        chk("x_col_addr", 32'(x_col_addr), 32'd0);
    endtask

    task automatic load_table_frame(input int f);
        for (int p = 0; p < M; p++) begin
            mem[p]     = vecs[f*M + p].col;
            exp_idx[p] = vecs[f*M + p].idx;
            exp_sc[p]  = vecs[f*M + p].score;
        end
    endtask

    task automatic run_frame(input int lat, input bit spur, input int bp, input bit early, input string tag);
        int waited;
        int fc;
        cur_tag     = tag;
        mem_lat     = lat;
        mem_spur    = spur;
        fc          = fin_count;
        class_ready = early;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int p = 0; p < M; p++) begin
            waited = 0;
            while (class_valid !== 1'b1 && waited < 300) begin
                @(negedge clk);
                waited++;
                start = (spur && waited == 2);
            end
            start = 1'b0;
            if (class_valid !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s/beat_timeout pixel=%0d actual=no_valid required=valid", tag, p);
                class_ready = 1'b0;
                return;
            end
            for (int k = 0; k < bp; k++) begin
                chk("bp_valid", 32'(class_valid), 32'd1);
                chk("bp_pixel", 32'(class_pixel), 32'(p));
                chk("bp_idx", 32'(class_idx), 32'(exp_idx[p]));
                chk("bp_score", class_score, exp_sc[p]);
                chk("bp_no_req", 32'(x_col_addr_ready), 32'd0);
                @(negedge clk);
            end
            chk("pixel", 32'(class_pixel), 32'(p));
            chk("idx", 32'(class_idx), 32'(exp_idx[p]));
            chk("score", class_score, exp_sc[p]);
            class_ready = 1'b1;
            @(negedge clk);
            chk("valid_after_hs", 32'(class_valid), 32'd0);
            if (p == M - 1) begin
                chk("finished_pulse", 32'(finished), 32'd1);
            end else begin
                chk("next_req", 32'(x_col_addr_ready), 32'd1);
                chk("next_addr", 32'(x_col_addr), 32'(p + 1));
                chk("no_early_finish", 32'(finished), 32'd0);
            end
            class_ready = early;
        end
        @(negedge clk);
        chk("finished_low", 32'(finished), 32'd0);
        chk("finished_once", 32'(fin_count - fc), 32'd1);
        class_ready = 1'b0;
    endtask

    initial begin
        int waited;
        int fc;
        logic [N*W-1:0] col;

        vecs[0] = '{mk(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F00_0000), 1, 32'h4000_0000};
        vecs[1] = '{mk(32'hC000_0000, 32'hBF80_0000, 32'hC040_0000, 32'hC080_0000), 1, 32'hBF80_0000};
        vecs[2] = '{mk(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000), 0, 32'h0000_0000};
        vecs[3] = '{mk(32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000), 1, 32'h0000_0000};
        vecs[4] = '{mk(32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000), 0, 32'h4000_0000};
        vecs[5] = '{mk(32'h8000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h8000_0000), 0, 32'h8000_0000};

        rst          = 1'b0;
        start        = 1'b0;
        class_ready  = 1'b0;
        start1       = 1'b0;
        class_ready1 = 1'b0;
        #1;
        check_idle("in_reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        load_table_frame(0);
        run_frame(1, 1'b0, 0, 1'b0, "basic");
        load_table_frame(1);
        run_frame(2, 1'b0, 5, 1'b0, "zero_tie_bp");
        load_table_frame(0);
        run_frame(7, 1'b1, 0, 1'b0, "lat7_spur");
        load_table_frame(1);
        run_frame(1, 1'b1, 0, 1'b1, "lat1_spur_early");

        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < M; p++) begin
                for (int r = 0; r < N; r++) col[r*W +: W] = rnd_f();
                if ($urandom_range(0, 2) == 0) col[3*W +: W] = col[W +: W];
                mem[p] = col;
                ref_argmax(col, exp_idx[p], exp_sc[p]);
            end
            run_frame($urandom_range(1, 5), f[0], (f == 2) ? 2 : 0, 1'b0, $sformatf("rand%0d", f));
        end

        // Abort during the scan of pixel 1, then rerun from pixel 0.
        cur_tag  = "abort";
        load_table_frame(0);
        mem_lat  = 1;
        mem_spur = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (class_valid !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("beat0_valid", 32'(class_valid), 32'd1);
        class_ready = 1'b1;
        @(negedge clk);
        class_ready = 1'b0;
        waited = 0;
        while (x_col_addr_ready !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("pixel1_req", 32'(x_col_addr_ready), 32'd1);
        repeat (2) @(negedge clk);
        fc  = fin_count;
        rst = 1'b0;
        #1;
        check_idle("abort_async");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("abort_released");
        cur_tag = "abort";
        chk("no_finish_on_abort", 32'(fin_count - fc), 32'd0);
        run_frame(3, 1'b0, 0, 1'b0, "after_abort");

        // Single class, single pixel.
        cur_tag = "n1m1";
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        waited = 0;
        while (class_valid1 !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("valid", 32'(class_valid1), 32'd1);
        chk("pixel", 32'(class_pixel1), 32'd0);
        chk("idx", 32'(class_idx1), 32'd0);
        chk("score", class_score1, 32'hC0A0_0000);
        class_ready1 = 1'b1;
        @(negedge clk);
        class_ready1 = 1'b0;
        chk("finished", 32'(finished1), 32'd1);
        chk("valid_after_hs", 32'(class_valid1), 32'd0);
        @(negedge clk);
        chk("finished_low", 32'(finished1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
